fpu_result_collector: RTL and testbench
=======================================

Name: fpu_result_collector

Overview:
Consumer side of the FPU result bus. It tracks every issued FPU operation together with its destination register and fixed per-op latency. When an operation's latency expires, it selects the matching slice of the 227-bit FPUResult bus and presents one registered writeback. Issue is stalled whenever two operations would complete in the same cycle, so the writeback port is never oversubscribed.

Parameters:
MAX_LAT, 8, depth of the pending-slot shift register; every LAT_* must be in 1..MAX_LAT
LAT_ADD, 2, cycles from issue until the fadd slice is valid on FPUResult
LAT_SUB, 2, same for fsub
LAT_MUL, 2, same for fmul
LAT_DIV, 4, same for fdiv
LAT_SQRT, 4, same for fsqrt
LAT_CMP, 1, same for feq/flt/fle
LAT_CVTWS, 3, same for fcvt.w.s
LAT_CVTSW, 3, same for fcvt.s.w

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
issue_valid  in  1  op presented to the FPU this cycle
issue_op  in  4  0 add, 1 sub, 2 mul, 3 div, 4 sqrt, 5 eq, 6 lt, 7 le, 8 cvtws, 9 cvtsw; 10-15 illegal
issue_rd  in  5  destination register
issue_ready  out  1  combinational; issue accepted iff issue_valid && issue_ready
flush  in  1  discard all pending ops
FPUResult  in  227  [31:0] fadd, [63:32] fsub, [95:64] fmul, [127:96] fdiv, [159:128] fsqrt, [160] feq, [161] fle, [162] flt, [194:163] fcvtws, [226:195] fcvtsw
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  5  writeback destination
wb_data  out  32  writeback value
wb_is_int  out  1  1 for eq/lt/le/cvtws (integer regfile); 0 otherwise
illegal_op  out  1  one-cycle pulse for an accepted illegal op
busy  out  1  any op pending or wb_valid high

Behaviour:
- Reset: all slots invalid; wb_valid=0, wb_rd=0, wb_data=0, wb_is_int=0, illegal_op=0. busy=0 on the cycle after rst is sampled. Reset asserted mid-operation drops all in-flight ops; no writeback occurs for them.
- Pending state: slot vector S[1..MAX_LAT], each slot holding {valid, op, rd}. Each posedge shifts S[i]<=S[i+1] and S[MAX_LAT]<=invalid. An accepted op with latency L writes S[L] on that edge. S[1] valid means its result is on FPUResult during the current cycle.
- Timing: op accepted in cycle t -> its FPUResult slice is sampled at the end of cycle t+L -> wb_valid=1 for exactly cycle t+L+1 with wb_rd, wb_data, wb_is_int.
- Slice select: eq/lt/le give {31'b0, bit}; all other ops give their full 32-bit slice. wb_data is 0 whenever wb_valid=0.
- issue_ready = !(S[L+1].valid) for L = latency of issue_op, i.e. no other op completes in the same cycle. If L=MAX_LAT, issue_ready=1. issue_ready depends on issue_op, but not on issue_valid.
- Illegal op: always ready; no slot written; illegal_op=1 in cycle t+1.
- flush: on that edge all slots are cleared, any issue in the same cycle is ignored, and wb_valid and illegal_op are 0 the next cycle. flush has priority over issue; rst has priority over flush.
- No backpressure on writeback; the consumer must accept every wb_valid.
- Back-to-back issue of same-latency ops is allowed every cycle.

Test Plan:
- Reset with issue_valid=1 held -> all outputs 0 the cycle after rst and no writeback afterwards; after rst release, add rd=3 at t=10 with FPUResult[31:0]=0x3F800000 in cycle 12 -> wb_valid=1 in cycle 13 only, wb_rd=3, wb_data=0x3F800000, wb_is_int=0.
- Conflict: div rd=1 at t=0 (completes t=4), then mul rd=2 at t=2 (would complete t=4) -> issue_ready=0 at t=2; mul retried at t=3 is accepted -> writebacks in cycle 5 (rd=1) and cycle 6 (rd=2).
- Compare: flt rd=7 at t=0 with FPUResult[162]=1 at t=1 -> wb_valid at t=2, wb_data=0x00000001, wb_is_int=1; same with bit=0 -> wb_data=0.
- Pipelined stream: add at t=0..5 with rd=0..5 -> issue_ready=1 throughout; six consecutive writebacks at t=3..8 with rd in order.
- Flush: sqrt at t=0 and add at t=1, flush at t=2 together with issue_valid for mul -> no writeback through t=10; busy=0 from t=3.
- Illegal: issue_op=12 at t=0 -> illegal_op=1 at t=1 only, no wb_valid; a following cvtsw rd=9 at t=1 writes back at t=5 with FPUResult[226:195].

Source files
------------

// File: rtl/fpu_result_collector.sv
// Collects FPU results: tracks in-flight ops in a latency-indexed slot vector and
// emits one registered writeback per completing op, stalling issue on completion clashes.
module fpu_result_collector #(
    parameter int MAX_LAT   = 8,
    parameter int LAT_ADD   = 2,
    parameter int LAT_SUB   = 2,
    parameter int LAT_MUL   = 2,
    parameter int LAT_DIV   = 4,
    parameter int LAT_SQRT  = 4,
    parameter int LAT_CMP   = 1,
    parameter int LAT_CVTWS = 3,
    parameter int LAT_CVTSW = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue_valid,
    input  logic [3:0]   issue_op,
    input  logic [4:0]   issue_rd,
    output logic         issue_ready,
    input  logic         flush,
    input  logic [226:0] FPUResult,
    output logic         wb_valid,
    output logic [4:0]   wb_rd,
    output logic [31:0]  wb_data,
    output logic         wb_is_int,
    output logic         illegal_op,
    output logic         busy
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_SQRT  = 4'd4;
    localparam logic [3:0] OP_EQ    = 4'd5;
    localparam logic [3:0] OP_LT    = 4'd6;
    localparam logic [3:0] OP_LE    = 4'd7;
    localparam logic [3:0] OP_CVTWS = 4'd8;
    localparam logic [3:0] OP_CVTSW = 4'd9;

    // Latency 0 marks an illegal opcode.
    function automatic int op_latency(input logic [3:0] op);
        case (op)
            OP_ADD:              return LAT_ADD;
            OP_SUB:              return LAT_SUB;
            OP_MUL:              return LAT_MUL;
            OP_DIV:              return LAT_DIV;
            OP_SQRT:             return LAT_SQRT;
            OP_EQ, OP_LT, OP_LE: return LAT_CMP;
            OP_CVTWS:            return LAT_CVTWS;
            OP_CVTSW:            return LAT_CVTSW;
            default:             return 0;
        endcase
    endfunction

    function automatic logic op_is_int(input logic [3:0] op);
        return (op == OP_EQ) || (op == OP_LT) || (op == OP_LE) || (op == OP_CVTWS);
    endfunction

    function automatic logic [31:0] select_slice(input logic [3:0] op, input logic [226:0] res);
        case (op)
            OP_ADD:   return res[31:0];
            OP_SUB:   return res[63:32];
            OP_MUL:   return res[95:64];
            OP_DIV:   return res[127:96];
            OP_SQRT:  return res[159:128];
            OP_EQ:    return {31'b0, res[160]};
            OP_LE:    return {31'b0, res[161]};
            OP_LT:    return {31'b0, res[162]};
            OP_CVTWS: return res[194:163];
            OP_CVTSW: return res[226:195];
            default:  return 32'b0;
        endcase
    endfunction

    logic [MAX_LAT:1] slot_vld;
    logic [3:0]       slot_op [1:MAX_LAT];
    logic [4:0]       slot_rd [1:MAX_LAT];

    int   issue_lat;
    logic issue_legal;
    logic accept;
    logic fire_p0;

    // A new op of latency L would land in S[L] exactly when S[L+1] shifts there.
    always_comb begin
        issue_lat   = op_latency(issue_op);
        issue_legal = (issue_lat != 0);
        issue_ready = 1'b1;
        for (int i = 2; i <= MAX_LAT; i++) begin
            if ((issue_lat + 1 == i) && slot_vld[i]) begin
                issue_ready = 1'b0;
            end
        end
    end

    assign accept  = issue_valid && issue_ready && !flush;
    assign fire_p0 = slot_vld[1] && !flush;
    assign busy    = (|slot_vld) || wb_valid;

    // Stage p0 -> p1: slot shift, issue insert and writeback register.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld   <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_is_int  <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            for (int i = 1; i < MAX_LAT; i++) begin
                slot_vld[i] <= slot_vld[i+1] && !flush;
            end
            slot_vld[MAX_LAT] <= 1'b0;
            if (accept && issue_legal) begin
                for (int i = 1; i <= MAX_LAT; i++) begin
                    if (i == issue_lat) begin
                        slot_vld[i] <= 1'b1;
                    end
                end
            end
            wb_valid   <= fire_p0;
            wb_rd      <= fire_p0 ? slot_rd[1] : 5'd0;
            wb_data    <= fire_p0 ? select_slice(slot_op[1], FPUResult) : 32'd0;
            wb_is_int  <= fire_p0 ? op_is_int(slot_op[1]) : 1'b0;
            illegal_op <= accept && !issue_legal;
        end
    end

    // Slot payload carries no reset; only slot_vld qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 1; i < MAX_LAT; i++) begin
            slot_op[i] <= slot_op[i+1];
            slot_rd[i] <= slot_rd[i+1];
        end
        if (accept && issue_legal) begin
            for (int i = 1; i <= MAX_LAT; i++) begin
                if (i == issue_lat) begin
                    slot_op[i] <= issue_op;
                    slot_rd[i] <= issue_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_result_collector.sv
// Bench for fpu_result_collector: table-driven issue vectors plus hand sequences,
// with writebacks checked against a cycle-stamped scoreboard.
module tb_fpu_result_collector;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         issue_valid = 1'b0;
    logic [3:0]   issue_op = 4'd0;
    logic [4:0]   issue_rd = 5'd0;
    logic         flush = 1'b0;
    logic [226:0] fpu_res = '0;
    logic         issue_ready, wb_valid, wb_is_int, illegal_op, busy;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;

    fpu_result_collector #(
        .MAX_LAT(8), .LAT_ADD(2), .LAT_SUB(2), .LAT_MUL(2), .LAT_DIV(4),
        .LAT_SQRT(4), .LAT_CMP(1), .LAT_CVTWS(3), .LAT_CVTSW(3)
    ) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_rd(issue_rd), .issue_ready(issue_ready), .flush(flush),
        .FPUResult(fpu_res), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_is_int(wb_is_int), .illegal_op(illegal_op), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          iss;
        int          wb;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        is_int;
    } exp_t;

    typedef struct {
        bit         v;
        logic [3:0] op;
        logic [4:0] rd;
        int         rdy;
    } vec_t;

    exp_t sb[$];
    int   ill_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   purge_at = -1;
    bit   checking = 1'b0;
    bit   prev_rst = 1'b0;

    function automatic int lat(logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2: return 2;
            4'd3, 4'd4:       return 4;
            4'd5, 4'd6, 4'd7: return 1;
            4'd8, 4'd9:       return 3;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [226:0] pat(int c);
        logic [226:0] r;
        logic [31:0]  cc;
        cc = 32'(c);
        r = '0;
        r[31:0]    = 32'h3F80_0000 ^ cc;
        r[63:32]   = 32'hC000_0000 ^ (cc << 4);
        r[95:64]   = 32'h4120_0000 ^ (cc * 3);
        r[127:96]  = 32'h4049_0FDB ^ (cc << 8);
        r[159:128] = 32'h3FB5_04F3 ^ cc;
        r[160]     = cc[0];
        r[161]     = cc[1];
        r[162]     = cc[2];
        r[194:163] = 32'h8000_0001 ^ cc;
        r[226:195] = 32'h4B00_0000 ^ cc;
        return r;
    endfunction

    function automatic logic [31:0] exp_slice(logic [226:0] r, logic [3:0] op);
        case (op)
            4'd0: return r[31:0];
            4'd1: return r[63:32];
            4'd2: return r[95:64];
            4'd3: return r[127:96];
            4'd4: return r[159:128];
            4'd5: return {31'b0, r[160]};
            4'd6: return {31'b0, r[162]};
            4'd7: return {31'b0, r[161]};
            4'd8: return r[194:163];
            4'd9: return r[226:195];
            default: return 32'b0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic sb_insert(exp_t e);
        int idx;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].wb > e.wb) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic step(bit r, bit v, logic [3:0] op, logic [4:0] rd, bit f, int exp_rdy);
        bit   model_rdy;
        int   l;
        exp_t e;
        @(posedge clk);
        #1;
        if (prev_rst) checking = 1'b1;
        prev_rst = r;
        cyc++;
        if (purge_at >= 0) begin
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].wb > purge_at) sb.delete(i);
            for (int i = ill_q.size() - 1; i >= 0; i--)
                if (ill_q[i] > purge_at) ill_q.delete(i);
            purge_at = -1;
        end
        fpu_res     = pat(cyc);
        rst         = r;
        issue_valid = v;
        issue_op    = op;
        issue_rd    = rd;
        flush       = f;
        l = lat(op);
        model_rdy = 1'b1;
        if (l != 0)
            foreach (sb[i]) if (sb[i].wb == cyc + l + 1) model_rdy = 1'b0;
        #1;
        if (checking) begin
            chk("issue_ready_model", {31'b0, issue_ready}, {31'b0, model_rdy});
            if (exp_rdy >= 0) chk("issue_ready_table", {31'b0, issue_ready}, 32'(exp_rdy));
        end
        if (r || f) begin
            purge_at = cyc;
        end else if (v && model_rdy) begin
            if (l == 0) begin
                ill_q.push_back(cyc + 1);
            end else begin
                e.iss    = cyc;
                e.wb     = cyc + l + 1;
                e.rd     = rd;
                e.data   = exp_slice(pat(cyc + l), op);
                e.is_int = (op == 4'd5) || (op == 4'd6) || (op == 4'd7) || (op == 4'd8);
                sb_insert(e);
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 1'b0, 4'd0, 5'd0, 1'b0, -1);
    endtask

    task automatic issue(logic [3:0] op, logic [4:0] rd, int rdy);
        step(1'b0, 1'b1, op, rd, 1'b0, rdy);
    endtask

    task automatic monitor_cycle();
        bit exp_wb, exp_busy, exp_ill;
        while (sb.size() > 0 && sb[0].wb < cyc) begin
            tests++;
            fails++;
            $display("FAIL missed_wb: rd=%0d expected at cycle %0d, still absent at cycle %0d",
                     sb[0].rd, sb[0].wb, cyc);
            void'(sb.pop_front());
        end
        exp_wb = (sb.size() > 0) && (sb[0].wb == cyc);
        exp_busy = 1'b0;
        foreach (sb[i]) if (sb[i].iss < cyc) exp_busy = 1'b1;
        chk("wb_valid", {31'b0, wb_valid}, {31'b0, exp_wb});
        chk("busy", {31'b0, busy}, {31'b0, exp_busy});
        if (exp_wb) begin
            chk("wb_rd", {27'b0, wb_rd}, {27'b0, sb[0].rd});
            chk("wb_data", wb_data, sb[0].data);
            chk("wb_is_int", {31'b0, wb_is_int}, {31'b0, sb[0].is_int});
            void'(sb.pop_front());
        end else begin
            chk("wb_data_idle", wb_data, 32'd0);
        end
        exp_ill = (ill_q.size() > 0) && (ill_q[0] == cyc);
        if (exp_ill) void'(ill_q.pop_front());
        chk("illegal_op", {31'b0, illegal_op}, {31'b0, exp_ill});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (checking) monitor_cycle();
        end
    end

    vec_t tbl [26] = '{
        '{1'b1, 4'd3, 5'd1,  1}, '{1'b0, 4'd0, 5'd0, -1}, '{1'b1, 4'd2, 5'd2,  0},
        '{1'b1, 4'd2, 5'd2,  1}, '{1'b0, 4'd0, 5'd0, -1}, '{1'b0, 4'd0, 5'd0, -1},
        '{1'b0, 4'd0, 5'd0, -1}, '{1'b1, 4'd0, 5'd0,  1}, '{1'b1, 4'd0, 5'd1,  1},
        '{1'b1, 4'd0, 5'd2,  1}, '{1'b1, 4'd0, 5'd3,  1}, '{1'b1, 4'd0, 5'd4,  1},
        '{1'b1, 4'd0, 5'd5,  1}, '{1'b1, 4'd6, 5'd7,  0}, '{1'b1, 4'd6, 5'd7,  1},
        '{1'b1, 4'd5, 5'd8,  1}, '{1'b1, 4'd7, 5'd9,  1}, '{1'b1, 4'd8, 5'd10, 1},
        '{1'b1, 4'd9, 5'd11, 1}, '{1'b1, 4'd4, 5'd12, 1}, '{1'b1, 4'd1, 5'd13, 1},
        '{1'b1, 4'd3, 5'd14, 1}, '{1'b1, 4'd0, 5'd15, 1}, '{1'b1, 4'd7, 5'd16, 0},
        '{1'b1, 4'd6, 5'd16, 0}, '{1'b0, 4'd0, 5'd0, -1}
    };

    initial begin
        // Reset held with an add presented every cycle.
        repeat (3) step(1'b1, 1'b1, 4'd0, 5'd5, 1'b0, -1);
        idle(1);
        #1;
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_is_int", {31'b0, wb_is_int}, 32'd0);
        chk("rst_illegal_op", {31'b0, illegal_op}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        idle(4);

        issue(4'd0, 5'd3, 1);
        idle(5);

        // Reset while a divide is in flight drops it.
        issue(4'd3, 5'd4, 1);
        idle(1);
        step(1'b1, 1'b0, 4'd0, 5'd0, 1'b0, -1);
        idle(7);

        foreach (tbl[i]) step(1'b0, tbl[i].v, tbl[i].op, tbl[i].rd, 1'b0, tbl[i].rdy);
        idle(8);

        // Back-to-back compares cover both result-bit polarities for each flavour.
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 8; j++)
                issue(4'(5 + k), 5'(16 + j), 1);
        idle(4);

        // Flush kills sqrt/add in flight and the mul issued alongside it.
        issue(4'd4, 5'd20, 1);
        issue(4'd0, 5'd21, 1);
        step(1'b0, 1'b1, 4'd2, 5'd22, 1'b1, -1);
        idle(8);

        // A writeback already registered survives a flush in its own cycle.
        issue(4'd0, 5'd23, 1);
        idle(2);
        step(1'b0, 1'b0, 4'd0, 5'd0, 1'b1, -1);
        idle(4);

        // Illegal opcodes: pulse only when accepted, never with flush.
        issue(4'd12, 5'd0, 1);
        issue(4'd9, 5'd9, 1);
        issue(4'd15, 5'd1, 1);
        step(1'b0, 1'b1, 4'd13, 5'd0, 1'b1, 1);
        idle(8);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("ill_drained", 32'(ill_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
